// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state type for the SPI register peripheral.
package spi_reg_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CNT_SAT    = FRAME_BITS + 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit
    } spi_state_e;

endpackage

// File: rtl/spi_reg_peripheral_if.sv
// SPI pin bundle: the controller drives sclk/copi/ncs, the target drives cipo.
interface spi_reg_peripheral_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;

    modport master (output sclk, output copi, output ncs, input cipo);
    modport slave  (input sclk, input copi, input ncs, output cipo);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input, with a history flop
// producing single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 target decoding 16-bit write frames into a small register file.
// Optional readback on cipo is enabled by defining SPI_READBACK_EN.
module spi_reg_peripheral
    import spi_reg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_REGS    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_reg_peripheral_if.slave  spi,
    output logic [7:0]           en_reg_out_7_0,
    output logic [7:0]           en_reg_out_15_8,
    output logic [7:0]           en_reg_pwm_7_0,
    output logic [7:0]           en_reg_pwm_15_8,
    output logic [7:0]           pwm_duty_cycle
);

    localparam int unsigned AW = $clog2(NUM_REGS);

    logic sclk_level, sclk_rise, sclk_fall;
    logic copi_level, copi_rise, copi_fall;
    logic ncs_level, ncs_rise, ncs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(spi.sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
        .clk(clk), .rst(rst), .din(spi.copi),
        .level(copi_level), .rise(copi_rise), .fall(copi_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk(clk), .rst(rst), .din(spi.ncs),
        .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
    );

    spi_state_e                state_q;
    logic [FRAME_BITS-1:0]     shift_q;
    logic [4:0]                bit_cnt_q;
    logic [7:0]                regs_q [NUM_REGS];

    logic frame_ok;
    assign frame_ok = (bit_cnt_q == 5'(FRAME_BITS)) && shift_q[15]
                      && (32'(shift_q[14:8]) < NUM_REGS);

`ifdef SPI_READBACK_EN
    logic       cipo_q;
    logic       armed_q;
    logic [7:0] tx_q;
    logic [6:0] rd_addr;
    logic [7:0] rd_val;

    // After eight bits the low byte of shift_q holds {R/W, addr}.
    assign rd_addr = shift_q[6:0];
    assign rd_val  = (32'(rd_addr) < NUM_REGS) ? regs_q[rd_addr[AW-1:0]] : 8'h00;
    assign spi.cipo = cipo_q;
    logic unused_sync;
    assign unused_sync = ^{sclk_level, copi_rise, copi_fall, ncs_level};
`else
    assign spi.cipo = 1'b0;
    logic unused_sync;
    assign unused_sync = ^{sclk_level, sclk_fall, copi_rise, copi_fall, ncs_level};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= 8'h00;
`ifdef SPI_READBACK_EN
            cipo_q    <= 1'b0;
            armed_q   <= 1'b0;
            tx_q      <= 8'h00;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ncs_fall) begin
                        state_q   <= StShift;
                        shift_q   <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                StShift: begin
                    if (ncs_rise) begin
                        state_q <= StCommit;
`ifdef SPI_READBACK_EN
                        cipo_q  <= 1'b0;
                        armed_q <= 1'b0;
`endif
                    end else begin
                        if (sclk_rise) begin
                            shift_q <= {shift_q[FRAME_BITS-2:0], copi_level};
                            if (bit_cnt_q != 5'(CNT_SAT)) bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
`ifdef SPI_READBACK_EN
                        // Falls after rises 8..15 present the addressed byte MSB first.
                        if (sclk_fall) begin
                            if (bit_cnt_q == 5'd8 && !shift_q[7]) begin
                                armed_q <= 1'b1;
                                cipo_q  <= rd_val[7];
                                tx_q    <= {rd_val[6:0], 1'b0};
                            end else if (armed_q && bit_cnt_q > 5'd8 && bit_cnt_q < 5'd16) begin
                                cipo_q  <= tx_q[7];
                                tx_q    <= {tx_q[6:0], 1'b0};
                            end
                        end
`endif
                    end
                end
                StCommit: begin
                    if (frame_ok) regs_q[shift_q[8+AW-1:8]] <= shift_q[7:0];
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO[AW-1:0]];
    assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI[AW-1:0]];
    assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO[AW-1:0]];
    assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI[AW-1:0]];
    assign pwm_duty_cycle  = regs_q[ADDR_DUTY[AW-1:0]];

endmodule
